// File: rtl/multichannel_counter_if.sv
// Slow-control byte bus: one address, one write strobe, registered read data.
interface multichannel_counter_if;
  logic [7:0] addr;
  logic [7:0] data_in;
  logic       we;
  logic [7:0] data_out;

  modport master (output addr, data_in, we, input data_out);
  modport slave  (input addr, data_in, we, output data_out);
endinterface

// File: rtl/multichannel_counter.sv
// Multichannel edge counter with gate timer, snapshot registers and byte-bus access.
// One lane per input channel: synchroniser, edge detect, live counter, snapshot.
module multichannel_counter_lane #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 res,
  input  logic                 sig,
  input  logic                 run,
  input  logic                 sat,
  input  logic                 clr,
  input  logic                 snap,
  output logic                 ovf,
  output logic [CNT_WIDTH-1:0] snap_cnt
);
  logic [1:0]           sync_q, sync_d;
  logic                 hist_q, hist_d, ev;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d, snap_q, snap_d, inc;

  always_comb begin
    sync_d = {sync_q[0], sig};
    hist_d = sync_q[1];
    ev     = run & sync_q[1] & ~hist_q;
    ovf    = ev & (&cnt_q);
    inc    = (ovf && sat) ? cnt_q : cnt_q + CNT_WIDTH'(ev);
    cnt_d  = inc;
    snap_d = snap_q;
    if (clr) begin
      cnt_d  = '0;
      snap_d = '0;
    end else if (snap) begin
      // the event of this very cycle closes into the snapshot
      snap_d = inc;
      cnt_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      sync_q <= '0;
      hist_q <= 1'b0;
      cnt_q  <= '0;
      snap_q <= '0;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
      cnt_q  <= cnt_d;
      snap_q <= snap_d;
    end
  end

  assign snap_cnt = snap_q;
endmodule

module multichannel_counter #(
  parameter int         N_CH      = 4,
  parameter int         CNT_WIDTH = 32,
  parameter logic [7:0] BASE_ADDR = 8'h26
) (
  input  logic                   clk,
  input  logic                   res,
  multichannel_counter_if.slave  bus,
  input  logic                   read_req,
  input  logic [N_CH-1:0]        signal,
  output logic                   snap_valid,
  output logic [31:0]            time_ex,
  output logic [N_CH*32-1:0]     data_ex
);
  logic [2:0]  ctrl_q, ctrl_d;
  logic [31:0] gate_q, gate_d, time_q, time_d, stime_q, stime_d, time_inc;
  logic [3:0]  st_q, st_d;
  logic        rr_q, sv_q, sv_d;
  logic [7:0]  dout_q, dout_d, off;
  logic [8:0]  off9;
  logic        hit, wr, cmd, clr, ack, snap, rr_rise, auto_t, wrap;
  logic [N_CH-1:0]                ovf_v;
  logic [N_CH-1:0][CNT_WIDTH-1:0] scnt;
  logic [N_CH-1:0][31:0]          snap_w;

  genvar g;
  generate
    for (g = 0; g < N_CH; g++) begin : g_lane
      multichannel_counter_lane #(.CNT_WIDTH(CNT_WIDTH)) u_lane (
        .clk(clk), .res(res), .sig(signal[g]), .run(ctrl_q[2]), .sat(ctrl_q[1]),
        .clr(clr), .snap(snap), .ovf(ovf_v[g]), .snap_cnt(scnt[g]));
      assign snap_w[g]          = 32'(scnt[g]);
      assign data_ex[32*g +: 32] = snap_w[g];
    end
  endgenerate

  always_comb begin
    off9     = {1'b0, bus.addr} - {1'b0, BASE_ADDR};
    hit      = ~off9[8];
    off      = off9[7:0];
    wr       = bus.we & hit;
    cmd      = wr && (off == 8'h00);
    clr      = cmd & bus.data_in[0];
    ack      = cmd & bus.data_in[2];
    rr_rise  = read_req & ~rr_q;
    auto_t   = ctrl_q[0] && (gate_q != 32'd0) && (time_q + 32'd1 == gate_q);
    snap     = ~clr & ((cmd & bus.data_in[1]) | rr_rise | auto_t);
    wrap     = ctrl_q[2] & (&time_q);
    time_inc = time_q + 32'(ctrl_q[2]);

    ctrl_d = ctrl_q;
    gate_d = gate_q;
    if (wr) begin
      case (off)
        8'h01: ctrl_d = bus.data_in[2:0];
        8'h02: gate_d[7:0]   = bus.data_in;
        8'h03: gate_d[15:8]  = bus.data_in;
        8'h04: gate_d[23:16] = bus.data_in;
        8'h05: gate_d[31:24] = bus.data_in;
        default: ;
      endcase
    end

    time_d  = time_inc;
    stime_d = stime_q;
    sv_d    = snap;
    st_d    = st_q;
    st_d[1] = st_q[1] | (|ovf_v);
    st_d[2] = st_q[2] | wrap;
    if (ack && !snap) begin
      st_d[0] = 1'b0;
      st_d[3] = 1'b0;
    end
    if (snap) begin
      if (!ack && st_q[0]) st_d[3] = 1'b1;
      st_d[0] = 1'b1;
      stime_d = time_inc;
      time_d  = '0;
    end
    if (clr) begin
      st_d    = '0;
      stime_d = '0;
      time_d  = '0;
    end

    dout_d = '0;
    if (hit) begin
      case (off)
        8'h01: dout_d = {5'b0, ctrl_q};
        8'h02: dout_d = gate_q[7:0];
        8'h03: dout_d = gate_q[15:8];
        8'h04: dout_d = gate_q[23:16];
        8'h05: dout_d = gate_q[31:24];
        8'h06: dout_d = {4'b0, st_q};
        8'h08: dout_d = stime_q[7:0];
        8'h09: dout_d = stime_q[15:8];
        8'h0a: dout_d = stime_q[23:16];
        8'h0b: dout_d = stime_q[31:24];
        default: ;
      endcase
      for (int c = 0; c < N_CH; c++)
        for (int b = 0; b < 4; b++)
          if (off == 8'(16 + 4*c + b)) dout_d = snap_w[c][8*b +: 8];
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      ctrl_q  <= 3'b100;
      gate_q  <= '0;
      time_q  <= '0;
      stime_q <= '0;
      st_q    <= '0;
      rr_q    <= 1'b0;
      sv_q    <= 1'b0;
      dout_q  <= '0;
    end else begin
      ctrl_q  <= ctrl_d;
      gate_q  <= gate_d;
      time_q  <= time_d;
      stime_q <= stime_d;
      st_q    <= st_d;
      rr_q    <= read_req;
      sv_q    <= sv_d;
      dout_q  <= dout_d;
    end
  end

  assign bus.data_out = dout_q;
  assign snap_valid   = sv_q;
  assign time_ex      = stime_q;
endmodule
